// File: rtl/fsm_reach_if.sv
// Sampling/record bundle between a bench (or debug host) and the reachability monitor.
// The master drives the sampled state bus; the slave (the monitor) returns the records.
interface fsm_reach_if #(
    parameter int STATE_W = 2,
    parameter int CNT_W   = 8
);
    logic                          sample_en;
    logic [STATE_W-1:0]            state_in;
    logic                          clear;
    logic [2**STATE_W-1:0]         visited;
    logic [2**(2*STATE_W)-1:0]     trans_seen;
    logic [CNT_W-1:0]              trans_count;
    logic                          all_visited;
    logic                          illegal_flag;
    logic [STATE_W-1:0]            illegal_state;
    logic                          stuck_flag;
    logic                          busy;

    modport master (
        output sample_en, state_in, clear,
        input  visited, trans_seen, trans_count, all_visited,
               illegal_flag, illegal_state, stuck_flag, busy
    );

    modport slave (
        input  sample_en, state_in, clear,
        output visited, trans_seen, trans_count, all_visited,
               illegal_flag, illegal_state, stuck_flag, busy
    );
endinterface

// File: rtl/fsm_reach_monitor.sv
// Runtime reachability checker for an encoded FSM state register.
// Records visited states, taken transitions and a saturating change count;
// flags the first illegal encoding (freezing all records) and stuck states.
//
// state | meaning
// ------+-------------------------------------------------------------
// ARMED | no legal sample since reset/clear; no previous state yet
// TRACK | previous state known; recording visits/transitions/dwell
// FAULT | illegal encoding seen; records frozen until clear/rst
module fsm_reach_monitor #(
    parameter int STATE_W     = 2,
    parameter int NUM_STATES  = 3,
    parameter int STUCK_LIMIT = 16,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    fsm_reach_if.slave   mon
);
    localparam int DW = $clog2(STUCK_LIMIT + 1);
    localparam logic [DW-1:0]      LIMIT = DW'(STUCK_LIMIT);
    // One extra bit so NUM_STATES == 2**STATE_W makes every encoding legal.
    localparam logic [STATE_W:0]   NUM_S = (STATE_W + 1)'(NUM_STATES);

    typedef enum logic [1:0] {ARMED, TRACK, FAULT} state_t;

    state_t                        state_r;
    logic [STATE_W-1:0]            prev_r;
    logic [DW-1:0]                 dwell_r;
    logic [2**STATE_W-1:0]         visited_r;
    logic [2**(2*STATE_W)-1:0]     trans_r;
    logic [CNT_W-1:0]              count_r;
    logic                          illegal_r;
    logic [STATE_W-1:0]            illegal_state_r;
    logic                          stuck_r;
    logic                          legal;

    assign legal = ({1'b0, mon.state_in} < NUM_S);

    // Sequencer and record registers; clear wins over a same-cycle sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ARMED;
            prev_r          <= '0;
            dwell_r         <= '0;
            visited_r       <= '0;
            trans_r         <= '0;
            count_r         <= '0;
            illegal_r       <= 1'b0;
            illegal_state_r <= '0;
            stuck_r         <= 1'b0;
        end else if (mon.clear) begin
            state_r         <= ARMED;
            prev_r          <= '0;
            dwell_r         <= '0;
            visited_r       <= '0;
            trans_r         <= '0;
            count_r         <= '0;
            illegal_r       <= 1'b0;
            illegal_state_r <= '0;
            stuck_r         <= 1'b0;
        end else if (mon.sample_en && state_r != FAULT) begin
            if (!legal) begin
                state_r <= FAULT;
                if (!illegal_r) begin
                    illegal_r       <= 1'b1;
                    illegal_state_r <= mon.state_in;
                end
            end else if (state_r == ARMED) begin
                visited_r[mon.state_in] <= 1'b1;
                prev_r                  <= mon.state_in;
                dwell_r                 <= DW'(1);
                state_r                 <= TRACK;
            end else if (mon.state_in != prev_r) begin
                visited_r[mon.state_in]      <= 1'b1;
                trans_r[{prev_r, mon.state_in}] <= 1'b1;
                if (count_r != '1)
                    count_r <= count_r + 1'b1;
                dwell_r <= DW'(1);
                prev_r  <= mon.state_in;
            end else if (dwell_r != LIMIT) begin
                dwell_r <= dwell_r + 1'b1;
                if (dwell_r == LIMIT - 1'b1)
                    stuck_r <= 1'b1;
            end
        end
    end

    // Outputs are the registers themselves; derived flags decode registered state only.
    always_comb begin
        mon.visited       = visited_r;
        mon.trans_seen    = trans_r;
        mon.trans_count   = count_r;
        mon.all_visited   = &visited_r[NUM_STATES-1:0];
        mon.illegal_flag  = illegal_r;
        mon.illegal_state = illegal_state_r;
        mon.stuck_flag    = stuck_r;
        mon.busy          = (state_r == TRACK);
    end
endmodule

// File: tb/tb_fsm_reach_monitor.sv
module tb_fsm_reach_monitor;
    localparam int SW    = 2;
    localparam int NS    = 3;
    localparam int LIMIT = 16;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsm_reach_if #(.STATE_W(SW), .CNT_W(CW)) bus ();

    fsm_reach_monitor #(.STATE_W(SW), .NUM_STATES(NS), .STUCK_LIMIT(LIMIT), .CNT_W(CW))
        dut (.clk(clk), .rst(rst), .mon(bus));

    typedef struct packed {
        logic [3:0]  vis;
        logic [15:0] tr;
        logic [7:0]  cnt;
        logic        allv;
        logic        ill;
        logic [1:0]  ills;
        logic        stk;
        logic        bsy;
    } snap_t;

    snap_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: sets of visited states/transitions, run length of the current value.
    bit m_vis[4];
    bit m_tr[4][4];
    int m_cnt, m_prev, m_run, m_ills;
    bit m_fault, m_ill, m_stuck;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_vis[i] = 0;
            for (int j = 0; j < 4; j++) m_tr[i][j] = 0;
        end
        m_cnt = 0; m_prev = -1; m_run = 0; m_ills = 0;
        m_fault = 0; m_ill = 0; m_stuck = 0;
    endfunction

    function automatic void model_step(bit en, int s, bit clr);
        if (clr) begin
            model_reset();
        end else if (en && !m_fault) begin
            if (s >= NS) begin
                m_fault = 1;
                if (!m_ill) begin m_ill = 1; m_ills = s; end
            end else if (m_prev < 0) begin
                m_vis[s] = 1; m_prev = s; m_run = 1;
            end else if (s != m_prev) begin
                m_vis[s] = 1;
                m_tr[m_prev][s] = 1;
                if (m_cnt < 255) m_cnt++;
                m_prev = s; m_run = 1;
            end else begin
                m_run++;
                if (m_run >= LIMIT) m_stuck = 1;
            end
        end
    endfunction

    function automatic snap_t model_snap();
        snap_t r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r.vis[i] = m_vis[i];
            for (int j = 0; j < 4; j++) r.tr[i*4+j] = m_tr[i][j];
        end
        r.cnt  = 8'(m_cnt);
        r.allv = m_vis[0] && m_vis[1] && m_vis[2];
        r.ill  = m_ill;
        r.ills = 2'(m_ills);
        r.stk  = m_stuck;
        r.bsy  = !m_fault && (m_prev >= 0);
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, snap_t e);
        chk({tag, ".visited"},       32'(bus.visited),       32'(e.vis));
        chk({tag, ".trans_seen"},    32'(bus.trans_seen),    32'(e.tr));
        chk({tag, ".trans_count"},   32'(bus.trans_count),   32'(e.cnt));
        chk({tag, ".all_visited"},   32'(bus.all_visited),   32'(e.allv));
        chk({tag, ".illegal_flag"},  32'(bus.illegal_flag),  32'(e.ill));
        chk({tag, ".illegal_state"}, 32'(bus.illegal_state), 32'(e.ills));
        chk({tag, ".stuck_flag"},    32'(bus.stuck_flag),    32'(e.stk));
        chk({tag, ".busy"},          32'(bus.busy),          32'(e.bsy));
    endtask

    // Monitor: every cycle that has an expected snapshot queued, compare away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            chk_all("mon", e);
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cyc(bit en, int s, bit clr);
        snap_t e;
        bus.sample_en = en;
        bus.state_in  = 2'(s);
        bus.clear     = clr;
        model_step(en, s, clr);
        e = model_snap();
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        bus.sample_en = 1'b0;
        bus.clear     = 1'b0;
    endtask

    // Asynchronous reset mid-cycle; outputs must drop without a clock edge.
    task automatic do_reset(string tag);
        snap_t z;
        z = '0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all(tag, z);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        bus.sample_en = 1'b0;
        bus.state_in  = '0;
        bus.clear     = 1'b0;
        model_reset();
        #1;
        chk_all("reset", model_snap());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // full cycle 0->1->2->0
        cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        do_reset("rst_a");

        // state 2 never reached
        cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(0, 0, 0);
        do_reset("rst_b");

        // illegal encoding freezes records
        cyc(1, 1, 0); cyc(1, 3, 0); cyc(1, 0, 0); cyc(1, 2, 0); cyc(0, 0, 0);
        do_reset("rst_c");

        // stuck after LIMIT identical samples
        for (int i = 0; i < 17; i++) cyc(1, 2, 0);
        cyc(0, 0, 0);
        do_reset("rst_d");

        // idle cycles do not advance dwell
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 13; i++) begin cyc(1, 0, 0); cyc(0, 1, 0); end
        cyc(1, 0, 0); cyc(0, 0, 0);
        do_reset("rst_e");

        // clear beats a same-cycle sample, then async reset while tracking
        cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 1, 1); cyc(0, 0, 0);
        cyc(1, 2, 0); cyc(1, 0, 0); cyc(1, 1, 0);
        do_reset("rst_mid");
        cyc(1, 3, 0); cyc(0, 0, 0);
        do_reset("rst_f");

        // counter saturation
        for (int i = 0; i < 300; i++) cyc(1, i % 2, 0);
        cyc(0, 0, 0);
        do_reset("rst_g");

        // randomized: repeats favoured to reach stuck, rare illegal values and clears
        last = 0;
        for (int n = 0; n < 2400; n++) begin
            int s;
            bit en, clr;
            en  = ($urandom % 4) != 0;
            clr = ($urandom % 150) == 0;
            if (($urandom % 100) < 75) s = last;
            else if (($urandom % 20) == 0) s = 3;
            else s = int'($urandom % 3);
            last = (s == 3) ? 0 : s;
            cyc(en, s, clr);
            if (n % 600 == 599) do_reset("rst_rand");
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
